// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StFault
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fields.sv
// Combinational RV32 field slicing of an instruction word.
module instr_fields (
    input  logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7
);

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, memory request handshake with timeout,
// instruction register capture and field decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic        busy,
    output logic        fetch_fault
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    fetch_state_e     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_inc;

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign mem_addr = pc;

    always_comb begin
        state_d = state;
        unique case (state)
            StIdle: begin
                // A PC write in the same cycle wins and drops the fetch.
                if (fetch_start && !pc_we) begin
                    state_d = (pc[1:0] == 2'b00) ? StReq : StFault;
                end
            end
            StReq: begin
                if (mem_ready) begin
                    state_d = StDone;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = StFault;
                end
            end
            StDone:  state_d = StIdle;
            StFault: if (pc_we) state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            old_pc      <= RESET_PC;
            ir          <= NOP;
            cnt         <= '0;
            mem_req     <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_d;
            mem_req     <= (state_d == StReq);
            busy        <= (state_d == StReq);
            instr_valid <= (state_d == StDone);
            fetch_fault <= (state_d == StFault);
            if (state == StReq) begin
                if (mem_ready) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end else begin
                    cnt <= cnt_inc;
                end
            end else begin
                // Held at zero outside REQ so every REQ entry starts from a clean count.
                cnt <= '0;
                if (pc_we) begin
                    pc <= pc_next;
                end
            end
        end
    end

    instr_fields u_fields (
        .ir     (ir),
        .opcode (opcode),
        .rd     (rd),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct7 (funct7)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand sequences for multi-cycle cases.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start, pc_we, mem_ready;
    logic [31:0] pc_next, mem_rdata;
    logic        mem_req, instr_valid, busy, fetch_fault;
    logic [31:0] mem_addr, ir, pc, old_pc;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_we       (pc_we),
        .pc_next     (pc_next),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .ir          (ir),
        .pc          (pc),
        .old_pc      (old_pc),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    typedef struct {
        logic        fs;
        logic        we;
        logic [31:0] nxt;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_iv;
        logic        e_busy;
        logic        e_ff;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
        logic [31:0] e_old;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d mem_req", i), mem_req, v.e_req);
        check($sformatf("v%0d instr_valid", i), instr_valid, v.e_iv);
        check($sformatf("v%0d busy", i), busy, v.e_busy);
        check($sformatf("v%0d fetch_fault", i), fetch_fault, v.e_ff);
        check($sformatf("v%0d pc", i), pc, v.e_pc);
        check($sformatf("v%0d ir", i), ir, v.e_ir);
        check($sformatf("v%0d old_pc", i), old_pc, v.e_old);
        if (v.e_req) check($sformatf("v%0d mem_addr", i), mem_addr, v.e_pc);
        check($sformatf("v%0d opcode", i), opcode, v.e_ir[6:0]);
        check($sformatf("v%0d rd", i), rd, v.e_ir[11:7]);
        check($sformatf("v%0d funct3", i), funct3, v.e_ir[14:12]);
        check($sformatf("v%0d rs1", i), rs1, v.e_ir[19:15]);
        check($sformatf("v%0d rs2", i), rs2, v.e_ir[24:20]);
        check($sformatf("v%0d funct7", i), funct7, v.e_ir[31:25]);
    endtask

    initial begin
        int iv_cnt;

        //           fs    we    nxt           rdy   rdata          req   iv    busy  ff    pc            ir            old_pc
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000013, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4,        32'h00500093, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h4,        32'h00500093, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h100,      32'h00500093, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,      32'h00500093, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h100,      32'h00500093, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h100,      32'h00500093, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h002081b3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104,      32'h002081b3, 32'h100};
        vecs[8]  = '{1'b0, 1'b1, 32'h300,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h300,      32'h002081b3, 32'h100};
        vecs[9]  = '{1'b0, 1'b1, 32'h102,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h102,      32'h002081b3, 32'h100};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h102,      32'h002081b3, 32'h100};
        vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 32'h102,      32'h002081b3, 32'h100};
        vecs[12] = '{1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h100,      32'h002081b3, 32'h100};

        rst = 1'b1;
        fetch_start = 1'b0;
        pc_we = 1'b0;
        pc_next = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        #12;
        check("rst mem_req", mem_req, 1'b0);
        check("rst instr_valid", instr_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst fetch_fault", fetch_fault, 1'b0);
        check("rst pc", pc, 32'h0);
        check("rst old_pc", old_pc, 32'h0);
        check("rst ir", ir, 32'h00000013);
        tick();
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            fetch_start = vecs[i].fs;
            pc_we       = vecs[i].we;
            pc_next     = vecs[i].nxt;
            mem_ready   = vecs[i].rdy;
            mem_rdata   = vecs[i].rdata;
            tick();
            check_vec(i, vecs[i]);
        end
        fetch_start = 1'b0;
        pc_we = 1'b0;
        mem_ready = 1'b0;

        // Three wait states: request held with a stable address, then one valid pulse.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wait%0d mem_req", k), mem_req, 1'b1);
            check($sformatf("wait%0d mem_addr", k), mem_addr, 32'h100);
            mem_ready = (k == 3);
            mem_rdata = 32'h00c00113;
            tick();
        end
        mem_ready = 1'b0;
        iv_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (instr_valid) iv_cnt++;
            tick();
        end
        check("wait valid pulses", iv_cnt, 1);
        check("wait pc", pc, 32'h104);
        check("wait ir", ir, 32'h00c00113);
        check("wait old_pc", old_pc, 32'h100);

        // Timeout: four REQ cycles without ready, then FAULT until a PC write.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tmo%0d busy", k), busy, 1'b1);
            tick();
        end
        check("tmo fetch_fault", fetch_fault, 1'b1);
        check("tmo busy", busy, 1'b0);
        check("tmo mem_req", mem_req, 1'b0);
        tick();
        tick();
        check("tmo fault held", fetch_fault, 1'b1);
        check("tmo pc", pc, 32'h104);
        pc_we = 1'b1;
        pc_next = 32'hFFFF_FFFC;
        tick();
        pc_we = 1'b0;
        check("tmo clear", fetch_fault, 1'b0);
        check("tmo new pc", pc, 32'hFFFF_FFFC);

        // PC wrap at the top of the address space.
        fetch_start = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000006f;
        tick();
        fetch_start = 1'b0;
        check("wrap mem_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        mem_ready = 1'b0;
        check("wrap instr_valid", instr_valid, 1'b1);
        check("wrap pc", pc, 32'h0);
        check("wrap old_pc", old_pc, 32'hFFFF_FFFC);
        check("wrap opcode", opcode, 7'h6f);

        // Reset in the middle of a fetch, with a late ready afterwards.
        tick();
        pc_we = 1'b1;
        pc_next = 32'h40;
        tick();
        pc_we = 1'b0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("mid busy", busy, 1'b1);
        check("mid mem_addr", mem_addr, 32'h40);
        #3;
        rst = 1'b1;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst mem_req", mem_req, 1'b0);
        check("mid rst pc", pc, 32'h0);
        check("mid rst ir", ir, 32'h00000013);
        mem_ready = 1'b1;
        mem_rdata = 32'habcdef01;
        iv_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (instr_valid) iv_cnt++;
            tick();
        end
        mem_ready = 1'b0;
        check("mid no valid", iv_cnt, 0);
        check("mid ir kept", ir, 32'h00000013);
        check("mid pc kept", pc, 32'h0);
        check("mid old_pc kept", old_pc, 32'h0);
        check("mid idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
